// File: rtl/bandai2003_unlock_host.sv
// Console-side host for the cartridge mapper lock/unlock handshake: pulses cartridge
// reset, drives the 0x5A/0xA5 unlock addresses, then captures and validates the serial reply.
module bandai2003_unlock_host #(
  parameter int unsigned RST_CYC   = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_TRIES = 3,
  parameter logic [15:0] SIG       = 16'h28A0,
  localparam int unsigned TW       = $clog2(MAX_TRIES + 1)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          START,
  input  logic          SI,
  output logic [7:0]    ADDR_O,
  output logic          ADDR_OE,
  output logic          CRST_On,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic          UNLOCK,
  output logic [15:0]   RXDATA,
  output logic [TW-1:0] TRIES
);

  localparam int unsigned RCW = $clog2(RST_CYC + 1);
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  localparam int unsigned BCW = 5;
  localparam logic [7:0]  ADDR_ACK = 8'h5A;
  localparam logic [7:0]  ADDR_NAK = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_ACK,
    S_NAK,
    S_HUNT,
    S_SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [15:0]     rxdata_d;
  logic [TW-1:0]   tries_d;
  logic            done_d, fail_d, unlock_d;
  logic [7:0]      addr_d;
  logic            addr_oe_d, crst_n_d, busy_d;
  logic            attempt_fail;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    to_cnt_d     = to_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    rxdata_d     = RXDATA;
    tries_d      = TRIES;
    done_d       = DONE;
    fail_d       = FAIL;
    unlock_d     = UNLOCK;
    attempt_fail = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          done_d    = 1'b0;
          fail_d    = 1'b0;
          unlock_d  = 1'b0;
          tries_d   = TW'(1);
          rst_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_CRST;
        end
      end
      S_CRST: begin
        if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
          state_d = S_ACK;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_ACK: state_d = S_NAK;
      S_NAK: state_d = S_HUNT;
      S_HUNT: begin
        // A start bit always wins over an expiring timeout
        if (!SI) begin
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == BCW'(16)) begin
          rxdata_d = shreg_q;
          if (!SI && (shreg_q == SIG)) begin
            done_d   = 1'b1;
            unlock_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            attempt_fail = 1'b1;
          end
        end else begin
          shreg_d   = {SI, shreg_q[15:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The failure edge doubles as the entry edge of the next cartridge reset
    if (attempt_fail) begin
      if (TRIES < TW'(MAX_TRIES)) begin
        tries_d   = TRIES + TW'(1);
        rst_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = S_CRST;
      end else begin
        fail_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    crst_n_d  = (state_d != S_CRST);
    busy_d    = (state_d != S_IDLE);
    addr_oe_d = (state_d == S_ACK) || (state_d == S_NAK);
    addr_d    = 8'h00;
    if (state_d == S_ACK) begin
      addr_d = ADDR_ACK;
    end else if (state_d == S_NAK) begin
      addr_d = ADDR_NAK;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      RXDATA    <= '0;
      TRIES     <= '0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      UNLOCK    <= 1'b0;
      ADDR_O    <= 8'h00;
      ADDR_OE   <= 1'b0;
      CRST_On   <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      RXDATA    <= rxdata_d;
      TRIES     <= tries_d;
      DONE      <= done_d;
      FAIL      <= fail_d;
      UNLOCK    <= unlock_d;
      ADDR_O    <= addr_d;
      ADDR_OE   <= addr_oe_d;
      CRST_On   <= crst_n_d;
      BUSY      <= busy_d;
    end
  end

endmodule

// File: tb/tb_bandai2003_unlock_host.sv
// Bench for bandai2003_unlock_host: behavioural mapper on SI, scoreboard of expected
// sequence outcomes checked by a monitor each time BUSY falls.
module tb_bandai2003_unlock_host;

  localparam int unsigned RST_CYC = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        START;
  logic        SI;
  logic [7:0]  ADDR_O;
  logic        ADDR_OE;
  logic        CRST_On;
  logic        BUSY;
  logic        DONE;
  logic        FAIL;
  logic        UNLOCK;
  logic [15:0] RXDATA;
  logic [1:0]  TRIES;

  bandai2003_unlock_host #(
    .RST_CYC(4), .TIMEOUT(64), .MAX_TRIES(3), .SIG(16'h28A0)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .SI(SI),
    .ADDR_O(ADDR_O), .ADDR_OE(ADDR_OE), .CRST_On(CRST_On), .BUSY(BUSY),
    .DONE(DONE), .FAIL(FAIL), .UNLOCK(UNLOCK), .RXDATA(RXDATA), .TRIES(TRIES)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        done;
    logic        fail;
    logic        unlock;
    logic [15:0] rx;
    int          tries;
    int          pulses;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [15:0] payload;
    logic        stop;
  } frame_t;

  exp_t   sb[$];
  frame_t fq[$];
  bit     silent;
  int     passed = 0;
  int     total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Mapper: arms on 0x5A then 0xA5, then sends start, 16 payload bits LSB-first, stop
  initial begin
    bit     armed;
    bit     prev5a;
    int     idx;
    frame_t fr;
    armed = 0; prev5a = 0; idx = 0; fr = '0;
    SI = 1'b1;
    forever begin
      @(negedge CLK);
      if (!RSTn || !CRST_On) begin
        armed = 0; prev5a = 0; idx = 0; SI = 1'b1;
      end else begin
        if (armed) begin
          if (idx == 0)       SI = 1'b0;
          else if (idx <= 16) SI = fr.payload[idx-1];
          else                SI = fr.stop;
          if (idx == 17) armed = 0;
          else idx++;
        end else begin
          SI = 1'b1;
        end
        if (ADDR_OE && ADDR_O == 8'hA5 && prev5a && !silent) begin
          armed = 1; idx = 0;
          fr = (fq.size() != 0) ? fq.pop_front() : frame_t'({16'h28A0, 1'b0});
        end
        prev5a = ADDR_OE && (ADDR_O == 8'h5A);
      end
    end
  end

  // Monitor: tracks CRST pulses and address drive, scores each completed sequence
  initial begin
    bit   busy_prev, len_bad, addr_bad, prev_crst_low;
    int   cyc, pulses, crst_run, oe_cnt;
    exp_t e;
    busy_prev = 0; len_bad = 0; addr_bad = 0; prev_crst_low = 0;
    cyc = 0; pulses = 0; crst_run = 0; oe_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        busy_prev = 0; len_bad = 0; addr_bad = 0; prev_crst_low = 0;
        cyc = 0; pulses = 0; crst_run = 0; oe_cnt = 0;
      end else begin
        if (BUSY) cyc++;
        if (!CRST_On) crst_run++;
        else if (crst_run != 0) begin
          pulses++;
          if (crst_run != RST_CYC) len_bad = 1;
          crst_run = 0;
        end
        if (ADDR_OE) begin
          if (oe_cnt % 2 == 0) begin
            if (ADDR_O != 8'h5A || !prev_crst_low) addr_bad = 1;
          end else if (ADDR_O != 8'hA5) addr_bad = 1;
          oe_cnt++;
        end else if (ADDR_O != 8'h00) addr_bad = 1;
        prev_crst_low = !CRST_On;
        if (busy_prev && !BUSY) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("done", 32'(DONE), 32'(e.done));
            check("fail", 32'(FAIL), 32'(e.fail));
            check("unlock", 32'(UNLOCK), 32'(e.unlock));
            check("rxdata", 32'(RXDATA), 32'(e.rx));
            check("tries", 32'(TRIES), 32'(e.tries));
            check("crst_pulses", 32'(pulses), 32'(e.pulses));
            check("crst_pulse_len_bad", 32'(len_bad), 32'd0);
            check("addr_oe_cycles", 32'(oe_cnt), 32'(2 * e.pulses));
            check("addr_sequence_bad", 32'(addr_bad), 32'd0);
            if (e.lat != 0) check("busy_cycles", 32'(cyc), 32'(e.lat));
          end
          len_bad = 0; addr_bad = 0; cyc = 0; pulses = 0; crst_run = 0; oe_cnt = 0;
        end
        busy_prev = BUSY;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_addr_o"}, 32'(ADDR_O), 32'h00);
    check({tag, "_addr_oe"}, 32'(ADDR_OE), 32'd0);
    check({tag, "_crst_on"}, 32'(CRST_On), 32'd1);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_fail"}, 32'(FAIL), 32'd0);
    check({tag, "_unlock"}, 32'(UNLOCK), 32'd0);
    check({tag, "_rxdata"}, 32'(RXDATA), 32'h0);
    check({tag, "_tries"}, 32'(TRIES), 32'd0);
  endtask

  task automatic run_seq(input exp_t e, input bit poke_start);
    int i;
    @(negedge CLK);
    START = 1'b1;
    sb.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    check("accept_done_clr", 32'(DONE), 32'd0);
    check("accept_fail_clr", 32'(FAIL), 32'd0);
    check("accept_unlock_clr", 32'(UNLOCK), 32'd0);
    check("accept_tries", 32'(TRIES), 32'd1);
    check("accept_busy", 32'(BUSY), 32'd1);
    if (poke_start) begin
      repeat (12) @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    i = 0;
    while (sb.size() != 0 && i < 3000) begin
      @(negedge CLK);
      i++;
    end
    if (sb.size() != 0) begin
      check("seq_completion_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    RSTn = 1'b0; START = 1'b0; silent = 0;
    repeat (3) @(negedge CLK);
    check_reset_values("por");
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Nominal unlock
    e = '{done:1, fail:0, unlock:1, rx:16'h28A0, tries:1, pulses:1, lat:24};
    run_seq(e, 0);

    // Corrupted payload on every attempt
    repeat (3) fq.push_back(frame_t'({16'h28A1, 1'b0}));
    e = '{done:0, fail:1, unlock:0, rx:16'h28A1, tries:3, pulses:3, lat:72};
    run_seq(e, 0);

    // START after FAIL, with a stray START during SHIFT
    e = '{done:1, fail:0, unlock:1, rx:16'h28A0, tries:1, pulses:1, lat:24};
    run_seq(e, 1);

    // Silent cartridge: RXDATA keeps the last captured payload
    silent = 1;
    e = '{done:0, fail:1, unlock:0, rx:16'h28A0, tries:3, pulses:3, lat:0};
    run_seq(e, 0);
    silent = 0;

    // Recovery: bad stop bit, then a good frame
    fq.push_back(frame_t'({16'h28A0, 1'b1}));
    fq.push_back(frame_t'({16'h28A0, 1'b0}));
    e = '{done:1, fail:0, unlock:1, rx:16'h28A0, tries:2, pulses:2, lat:48};
    run_seq(e, 0);

    // Reset just before payload bit 7 is sampled
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (14) @(negedge CLK);
    check("busy_mid_shift", 32'(BUSY), 32'd1);
    #2 RSTn = 1'b0;
    #1 check_reset_values("mid_shift_rst");
    @(negedge CLK);
    #2 RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    e = '{done:1, fail:0, unlock:1, rx:16'h28A0, tries:1, pulses:1, lat:24};
    run_seq(e, 0);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
